cpu_mc_ctrl: RTL and testbench

CPU_MC_CTRL -- requirements
Module: cpu_mc_ctrl

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cpu_inst_decode.sv | 32 +++
 rtl/cpu_mc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cpu_mc_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcode
// constants, FSM state encoding, instruction class encoding, ALUOp and
// pc_src codes, and the bundle of datapath control strobes.
package cpu_pkg;

    localparam int unsigned OPC_W    = 11;
    localparam int unsigned CB_PFX_W = 8;
    localparam int unsigned B_PFX_W  = 6;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned CLASS_W  = 3;

    // Full-width opcodes
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_HALT = 11'b11111111111;

    // Prefix-matched opcodes (low bits belong to the immediate)
    localparam logic [CB_PFX_W-1:0] OPC_CBZ_PFX  = 8'b10110100;
    localparam logic [CB_PFX_W-1:0] OPC_CBNZ_PFX = 8'b10110101;
    localparam logic [B_PFX_W-1:0]  OPC_B_PFX    = 6'b000101;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NOP   = 3'd0,
        CLS_LDUR  = 3'd1,
        CLS_STUR  = 3'd2,
        CLS_RTYPE = 3'd3,
        CLS_CBZ   = 3'd4,
        CLS_CBNZ  = 3'd5,
        CLS_B     = 3'd6,
        CLS_HALT  = 3'd7
    } inst_class_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASSB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;

    // Datapath control strobes driven by the controller
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic [1:0] pc_src;
        logic       reg2loc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_rtype(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) ||
               (opc == OPC_AND) || (opc == OPC_ORR);
    endfunction

endpackage

// File: rtl/cpu_inst_decode.sv
// Combinational opcode classifier.
// Ports:
//   inst31_21  - opcode field of the instruction register
//   inst_class - instruction class (anything unrecognised is CLS_NOP)
module cpu_inst_decode
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] inst31_21,
    output inst_class_t      inst_class
);

    // Exact opcodes first, then prefix matches for branch immediates
    always_comb begin
        inst_class = CLS_NOP;
        if (inst31_21 == OPC_LDUR) begin
            inst_class = CLS_LDUR;
        end else if (inst31_21 == OPC_STUR) begin
            inst_class = CLS_STUR;
        end else if (is_rtype(inst31_21)) begin
            inst_class = CLS_RTYPE;
        end else if (inst31_21[OPC_W-1 -: CB_PFX_W] == OPC_CBZ_PFX) begin
            inst_class = CLS_CBZ;
        end else if (inst31_21[OPC_W-1 -: CB_PFX_W] == OPC_CBNZ_PFX) begin
            inst_class = CLS_CBNZ;
        end else if (inst31_21[OPC_W-1 -: B_PFX_W] == OPC_B_PFX) begin
            inst_class = CLS_B;
        end else if (inst31_21 == OPC_HALT) begin
            inst_class = CLS_HALT;
        end
    end

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle CPU main controller (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional feature macro: CPU_MC_MEMWAIT_EN -- MEM waits for mem_ready with
// a MEM_TIMEOUT-cycle abort (mem_err pulse); otherwise MEM is one cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   inst31_21       - opcode field, sampled only in DECODE
//   zero            - ALU zero flag (used by CBZ/CBNZ in EXEC)
//   mem_ready       - data memory access complete
//   pc_write, ir_write, pc_src            - PC/IR control
//   Reg2Loc, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, ALUOp - datapath
//   halted, mem_err, state                - status / debug view
module cpu_mc_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] inst31_21,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic [1:0]       pc_src,
    output logic             Reg2Loc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic             halted,
    output logic             mem_err,
    output logic [STATE_W-1:0] state
);

    state_t      state_q, state_d;
    inst_class_t class_q, dec_class, cur_class;
    ctrl_t       ctrl_c, ctrl_out;
    logic        halt_c;

    cpu_inst_decode u_dec (
        .inst31_21  (inst31_21),
        .inst_class (dec_class)
    );

    // DECODE acts on the live classification; later states use the latched one
    assign cur_class = (state_q == ST_DECODE) ? dec_class : class_q;

`ifdef CPU_MC_MEMWAIT_EN
    localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_c;
    logic             mem_abort_c;

    // Counter has hit the limit: this MEM cycle is the abort cycle
    assign mem_abort_c = (state_q == ST_MEM) && (wait_q == CNT_W'(MEM_TIMEOUT));
`else
    logic unused_c;
    assign unused_c = ^{mem_ready, 32'(MEM_TIMEOUT)};
`endif

    // State, class and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CLS_NOP;
`ifdef CPU_MC_MEMWAIT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                class_q <= dec_class;
            end
`ifdef CPU_MC_MEMWAIT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Next state and Moore control decode
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        halt_c  = 1'b0;
`ifdef CPU_MC_MEMWAIT_EN
        wait_d  = wait_q;
        err_c   = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                ctrl_c.ir_write = 1'b1;
                ctrl_c.pc_write = 1'b1;
                ctrl_c.pc_src   = PCSRC_SEQ;
                state_d         = ST_DECODE;
            end
            ST_DECODE: begin
                case (cur_class)
                    CLS_HALT: state_d = ST_HALT;
                    CLS_B: begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.pc_src   = PCSRC_BRANCH;
                        state_d         = ST_FETCH;
                    end
                    CLS_NOP: state_d = ST_FETCH;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cur_class)
                    CLS_RTYPE: begin
                        ctrl_c.alu_src = 1'b0;
                        ctrl_c.alu_op  = ALUOP_FUNCT;
                        ctrl_c.reg2loc = 1'b0;
                        state_d        = ST_WB;
                    end
                    CLS_LDUR, CLS_STUR: begin
                        ctrl_c.alu_src = 1'b1;
                        ctrl_c.alu_op  = ALUOP_ADD;
                        state_d        = ST_MEM;
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        ctrl_c.reg2loc = 1'b1;
                        ctrl_c.alu_op  = ALUOP_PASSB;
                        if ((cur_class == CLS_CBZ) ? zero : !zero) begin
                            ctrl_c.pc_write = 1'b1;
                            ctrl_c.pc_src   = PCSRC_BRANCH;
                        end
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
`ifdef CPU_MC_MEMWAIT_EN
                if (mem_abort_c) begin
                    // Abort: strobes dropped, no writeback
                    err_c   = 1'b1;
                    wait_d  = '0;
                    state_d = ST_FETCH;
                end else begin
                    ctrl_c.mem_read  = (cur_class == CLS_LDUR);
                    ctrl_c.mem_write = (cur_class == CLS_STUR);
                    ctrl_c.reg2loc   = (cur_class == CLS_STUR);
                    if (mem_ready) begin
                        wait_d  = '0;
                        state_d = (cur_class == CLS_LDUR) ? ST_WB : ST_FETCH;
                    end else begin
                        wait_d  = wait_q + CNT_W'(1);
                    end
                end
`else
                ctrl_c.mem_read  = (cur_class == CLS_LDUR);
                ctrl_c.mem_write = (cur_class == CLS_STUR);
                ctrl_c.reg2loc   = (cur_class == CLS_STUR);
                state_d          = (cur_class == CLS_LDUR) ? ST_WB : ST_FETCH;
`endif
            end
            ST_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = (cur_class == CLS_LDUR);
                state_d           = ST_FETCH;
            end
            ST_HALT: begin
                halt_c = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Everything reads as zero while reset is asserted
    assign ctrl_out = rst ? '0 : ctrl_c;

    assign pc_write = ctrl_out.pc_write;
    assign ir_write = ctrl_out.ir_write;
    assign pc_src   = ctrl_out.pc_src;
    assign Reg2Loc  = ctrl_out.reg2loc;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign MemtoReg = ctrl_out.mem_to_reg;
    assign ALUSrc   = ctrl_out.alu_src;
    assign RegWrite = ctrl_out.reg_write;
    assign ALUOp    = ctrl_out.alu_op;
    assign halted   = !rst && halt_c;
    assign state    = rst ? STATE_W'(0) : state_q;

`ifdef CPU_MC_MEMWAIT_EN
    assign mem_err  = !rst && err_c;
`else
    assign mem_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Self-checking bench for cpu_mc_ctrl: per-cycle comparison against a
// transaction-level model, a latency/branch table, and reset corner cases.
module tb_cpu_mc_ctrl;

    localparam int unsigned TMO = 15;
`ifdef CPU_MC_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [10:0] inst31_21;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write;
    logic [1:0]  pc_src;
    logic        Reg2Loc, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic        halted, mem_err;
    logic [2:0]  state;

    cpu_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst31_21 (inst31_21),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .pc_src    (pc_src),
        .Reg2Loc   (Reg2Loc),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .ALUOp     (ALUOp),
        .halted    (halted),
        .mem_err   (mem_err),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {K_NOP, K_LDUR, K_STUR, K_RTYPE, K_CBZ, K_CBNZ, K_B, K_HALT} kind_e;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic       irw;
        logic [1:0] pcs;
        logic       r2l;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       asrc;
        logic       rw;
        logic [1:0] aop;
        logic       hlt;
        logic       merr;
    } obs_t;

    typedef struct {
        string       name;
        logic [10:0] inst;
        logic        z;
        int          w;
        int          lat;
        bit          taken;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    logic rdy_q[$];

    function automatic obs_t sample();
        obs_t o;
        o.st = state;   o.pcw = pc_write; o.irw = ir_write; o.pcs = pc_src;
        o.r2l = Reg2Loc; o.mr = MemRead; o.mw = MemWrite; o.m2r = MemtoReg;
        o.asrc = ALUSrc; o.rw = RegWrite; o.aop = ALUOp;
        o.hlt = halted; o.merr = mem_err;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got st=%0d bits=%h, required st=%0d bits=%h",
                     tag, $time, act.st, act, exp.st, exp);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", tag, act, exp);
        end
    endtask

    // Instruction classes straight from the opcode table
    function automatic kind_e classify(input logic [10:0] i);
        if (i ==? 11'b11111000010) return K_LDUR;
        if (i ==? 11'b11111000000) return K_STUR;
        if ((i ==? 11'b10001011000) || (i ==? 11'b11001011000) ||
            (i ==? 11'b10001010000) || (i ==? 11'b10101010000)) return K_RTYPE;
        if (i ==? 11'b10110100???) return K_CBZ;
        if (i ==? 11'b10110101???) return K_CBNZ;
        if (i ==? 11'b000101?????) return K_B;
        if (i ==? 11'b11111111111) return K_HALT;
        return K_NOP;
    endfunction

    // Extra MEM cycles beyond the first one
    function automatic int memx(input int w);
        if (!MEMWAIT) return 0;
        return (w < int'(TMO)) ? w : int'(TMO);
    endfunction

    task automatic push(input obs_t o, input logic r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endtask

    // Expected per-cycle trace of one instruction (plus mem_ready stimulus)
    task automatic build(input logic [10:0] inst, input logic z, input int w);
        kind_e k;
        obs_t  o;
        k = classify(inst);
        exp_q.delete();
        rdy_q.delete();
        o = '0; o.st = 3'd0; o.irw = 1'b1; o.pcw = 1'b1; o.pcs = 2'b00;
        push(o, 1'($urandom));
        o = '0; o.st = 3'd1;
        if (k == K_B) begin o.pcw = 1'b1; o.pcs = 2'b01; end
        push(o, 1'($urandom));
        if (k == K_HALT) begin
            o = '0; o.st = 3'd5; o.hlt = 1'b1;
            for (int i = 0; i < 22; i++) push(o, 1'($urandom));
            return;
        end
        if (k == K_B || k == K_NOP) return;
        o = '0; o.st = 3'd2;
        if (k == K_RTYPE) begin
            o.aop = 2'b10;
        end else if (k == K_LDUR || k == K_STUR) begin
            o.asrc = 1'b1; o.aop = 2'b00;
        end else begin
            o.r2l = 1'b1; o.aop = 2'b01;
            if ((k == K_CBZ && z) || (k == K_CBNZ && !z)) begin
                o.pcw = 1'b1; o.pcs = 2'b01;
            end
        end
        push(o, 1'($urandom));
        if (k == K_CBZ || k == K_CBNZ) return;
        if (k == K_LDUR || k == K_STUR) begin
            o = '0; o.st = 3'd3;
            o.mr = (k == K_LDUR); o.mw = (k == K_STUR); o.r2l = (k == K_STUR);
            if (!MEMWAIT) begin
                push(o, 1'($urandom));
            end else if (w < int'(TMO)) begin
                for (int i = 0; i < w; i++) push(o, 1'b0);
                push(o, 1'b1);
            end else begin
                for (int i = 0; i < int'(TMO); i++) push(o, 1'b0);
                o = '0; o.st = 3'd3; o.merr = 1'b1;
                push(o, 1'b0);
                return;
            end
            if (k == K_STUR) return;
        end
        o = '0; o.st = 3'd4; o.rw = 1'b1; o.m2r = (k == K_LDUR);
        push(o, 1'($urandom));
    endtask

    // Drive one instruction cycle by cycle; opcode valid only in DECODE
    task automatic play(input string tag, input logic [10:0] inst, input logic z,
                        input int w, input int limit);
        build(inst, z, w);
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            @(negedge clk);
            inst31_21 = (i == 1) ? inst : 11'($urandom);
            zero      = (i == 2) ? z : 1'($urandom);
            mem_ready = rdy_q[i];
            #1;
            check($sformatf("%s[%0d]", tag, i), exp_q[i]);
        end
    endtask

    // Reactive run: count cycles until the DUT returns to FETCH
    task automatic measure(input vec_t v, output int lat, output bit taken);
        int mcnt;
        bit done;
        lat = -1; taken = 1'b0; mcnt = 0; done = 1'b0;
        for (int c = 1; c <= 64 && !done; c++) begin
            @(negedge clk);
            inst31_21 = (state == 3'd1) ? v.inst : 11'($urandom);
            zero      = v.z;
            mem_ready = (state == 3'd3) ? (mcnt >= v.w) : 1'($urandom);
            if (state == 3'd3) mcnt++;
            #1;
            if (pc_write && pc_src == 2'b01) taken = 1'b1;
            @(posedge clk);
            #1;
            if (state == 3'd0) begin
                done = 1'b1;
                lat  = c;
            end
        end
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        inst31_21 = 11'($urandom);
        #1;
        check(tag, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [10:0] rand_inst();
        logic [10:0] r;
        case ($urandom_range(0, 7))
            0: r = 11'b11111000010;
            1: r = 11'b11111000000;
            2: case ($urandom_range(0, 3))
                   0: r = 11'b10001011000;
                   1: r = 11'b11001011000;
                   2: r = 11'b10001010000;
                   default: r = 11'b10101010000;
               endcase
            3: r = {8'b10110100, 3'($urandom)};
            4: r = {8'b10110101, 3'($urandom)};
            5: r = {6'b000101, 5'($urandom)};
            default: r = 11'($urandom);
        endcase
        if (r == 11'b11111111111) r = 11'b0;
        return r;
    endfunction

    vec_t vt[14];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   tk;
        logic [10:0] ri;
        int   rw;
        logic rz;

        vt[0]  = '{"add",     11'b10001011000, 1'b0, 0,  4,              1'b0};
        vt[1]  = '{"sub",     11'b11001011000, 1'b1, 0,  4,              1'b0};
        vt[2]  = '{"and",     11'b10001010000, 1'b0, 0,  4,              1'b0};
        vt[3]  = '{"orr",     11'b10101010000, 1'b1, 0,  4,              1'b0};
        vt[4]  = '{"ldur_w0", 11'b11111000010, 1'b0, 0,  5,              1'b0};
        vt[5]  = '{"ldur_w3", 11'b11111000010, 1'b0, 3,  5 + memx(3),    1'b0};
        vt[6]  = '{"stur_w2", 11'b11111000000, 1'b0, 2,  4 + memx(2),    1'b0};
        vt[7]  = '{"stur_to", 11'b11111000000, 1'b0, 40, 4 + memx(40),   1'b0};
        vt[8]  = '{"cbz_t",   11'b10110100101, 1'b1, 0,  3,              1'b1};
        vt[9]  = '{"cbz_n",   11'b10110100010, 1'b0, 0,  3,              1'b0};
        vt[10] = '{"cbnz_t",  11'b10110101111, 1'b0, 0,  3,              1'b1};
        vt[11] = '{"cbnz_n",  11'b10110101000, 1'b1, 0,  3,              1'b0};
        vt[12] = '{"b",       11'b00010110011, 1'b0, 0,  2,              1'b1};
        vt[13] = '{"nop",     11'b00000000000, 1'b1, 0,  2,              1'b0};

        rst = 1'b1; inst31_21 = '0; zero = 1'b0; mem_ready = 1'b0;

        // Outputs must read zero throughout reset
        @(negedge clk); #1; check("rst_hold0", '0);
        @(negedge clk); inst31_21 = 11'b11111111111; #1; check("rst_hold1", '0);
        @(posedge clk); #1; rst = 1'b0;

        // Directed traces
        play("add",     11'b10001011000, 1'b0, 0,  1000);
        play("ldur_w3", 11'b11111000010, 1'b0, 3,  1000);
        play("cbz_z1",  11'b10110100110, 1'b1, 0,  1000);
        play("cbz_z0",  11'b10110100110, 1'b0, 0,  1000);
        play("cbnz_z0", 11'b10110101001, 1'b0, 0,  1000);
        play("cbnz_z1", 11'b10110101001, 1'b1, 0,  1000);
        play("stur_to", 11'b11111000000, 1'b0, 30, 1000);
        play("ldur_to", 11'b11111000010, 1'b0, 15, 1000);
        play("ldur_14", 11'b11111000010, 1'b0, 14, 1000);
        play("b",       11'b00010100000, 1'b1, 0,  1000);
        play("nop",     11'b01010101010, 1'b1, 0,  1000);

        // Latency and branch-taken table
        for (int i = 0; i < 14; i++) begin
            measure(vt[i], lat, tk);
            check_int({vt[i].name, "_lat"},   lat,      vt[i].lat);
            check_int({vt[i].name, "_taken"}, int'(tk), int'(vt[i].taken));
        end

        // Reset in the middle of a MEM wait: no writeback may follow
        play("ldur_cut", 11'b11111000010, 1'b0, 10, MEMWAIT ? 5 : 3);
        reset_pulse("rst_mem");
        play("after_rst_nop", 11'b00000000001, 1'b0, 0, 1000);
        play("after_rst_add", 11'b10001011000, 1'b0, 0, 1000);

        // HALT is terminal until reset
        play("halt", 11'b11111111111, 1'b0, 0, 1000);
        reset_pulse("rst_halt");
        play("post_halt", 11'b10001010000, 1'b0, 0, 1000);

        // Random instruction stream against the model
        for (int n = 0; n < 150; n++) begin
            ri = rand_inst();
            rz = 1'($urandom);
            rw = ($urandom_range(0, 9) == 0) ? 15 + int'($urandom_range(0, 4))
                                             : int'($urandom_range(0, 4));
            play("rand", ri, rz, rw, 1000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
